// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: sizing, tag range, instruction
// classes, per-entry record and the redirect-PC helper.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned ROB_W    = 4;

    // ROBRange: an entry tag / pointer
    typedef logic [ROB_W-1:0] rob_range_t;
    // Occupancy, 0..ROB_SIZE inclusive
    typedef logic [ROB_W:0]   rob_count_t;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2,
        ROB_EXIT   = 2'd3
    } rob_type_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_t   kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
        logic        real_taken;
        logic [31:0] target;
        logic [31:0] val;
    } rob_entry_t;

    // Correct fetch address after a mispredicted branch
    function automatic logic [31:0] redirect_pc(input rob_entry_t e);
        return e.real_taken ? e.target : e.pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-query and retire signals of the reorder buffer.
// slave: the reorder buffer itself; master: dispatcher/CDB/commit side.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        rdy;

    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_predTaken;
    logic        issue_ready;
    logic [31:0] issue_val;
    logic        rob_full;
    rob_range_t  issue_tag;

    logic        alu_valid;
    rob_range_t  alu_tag;
    logic [31:0] alu_val;
    logic        alu_realTaken;
    logic [31:0] alu_target;

    logic        lsb_valid;
    rob_range_t  lsb_tag;
    logic [31:0] lsb_val;

    rob_range_t  query_tagj;
    rob_range_t  query_tagk;
    logic        query_rdyj;
    logic        query_rdyk;
    logic [31:0] query_valj;
    logic [31:0] query_valk;

    logic        commit_valid;
    logic [4:0]  ROB_rd;
    rob_range_t  ROB_rdTag;
    logic [31:0] ROB_rdVal;
    logic        commit_store;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        halt;

    modport master (
        output rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_predTaken,
               issue_ready, issue_val, alu_valid, alu_tag, alu_val, alu_realTaken,
               alu_target, lsb_valid, lsb_tag, lsb_val, query_tagj, query_tagk,
        input  rob_full, issue_tag, query_rdyj, query_rdyk, query_valj, query_valk,
               commit_valid, ROB_rd, ROB_rdTag, ROB_rdVal, commit_store, rollback,
               rollback_pc, halt
    );

    modport slave (
        input  rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_predTaken,
               issue_ready, issue_val, alu_valid, alu_tag, alu_val, alu_realTaken,
               alu_target, lsb_valid, lsb_tag, lsb_val, query_tagj, query_tagk,
        output rob_full, issue_tag, query_rdyj, query_rdyk, query_valj, query_valk,
               commit_valid, ROB_rd, ROB_rdTag, ROB_rdVal, commit_store, rollback,
               rollback_pc, halt
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire of out-of-order results, with
// register commit, store commit, misprediction rollback and halt.
// Optional: define ROB_QUERY_BYPASS_EN to forward same-cycle CDB results
// to the operand query ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic           clk,
    input logic           rst,
    reorder_buffer_if.slave bus
);

    rob_entry_t entries [ROB_SIZE];
    rob_range_t head;
    rob_range_t tail;
    rob_count_t count;

    rob_entry_t head_e;
    logic       full;
    logic       retire;
    logic       mispredict;
    logic       flush;
    logic       issue_take;

    // Retire/flush/allocate decisions from the current registered state
    always_comb begin
        head_e     = entries[head];
        full       = (count == rob_count_t'(ROB_SIZE));
        retire     = (count != '0) && head_e.busy && head_e.ready;
        mispredict = retire && (head_e.kind == ROB_BRANCH)
                     && (head_e.pred_taken != head_e.real_taken);
        // Flush on the edge that raises rollback and again while it is high
        flush      = bus.rollback || mispredict;
        // A full buffer still accepts into the slot freed by a same-cycle retire
        issue_take = bus.issue_valid && (!full || retire) && !flush;
    end

    assign bus.rob_full  = full;
    assign bus.issue_tag = tail;

    // Operand query: stored entry state, optionally overridden by the CDBs
    always_comb begin
        bus.query_rdyj = entries[bus.query_tagj].busy && entries[bus.query_tagj].ready;
        bus.query_valj = entries[bus.query_tagj].val;
        bus.query_rdyk = entries[bus.query_tagk].busy && entries[bus.query_tagk].ready;
        bus.query_valk = entries[bus.query_tagk].val;
`ifdef ROB_QUERY_BYPASS_EN
        if (bus.lsb_valid && (bus.lsb_tag == bus.query_tagj)) begin
            bus.query_rdyj = 1'b1;
            bus.query_valj = bus.lsb_val;
        end
        if (bus.alu_valid && (bus.alu_tag == bus.query_tagj)) begin
            bus.query_rdyj = 1'b1;
            bus.query_valj = bus.alu_val;
        end
        if (bus.lsb_valid && (bus.lsb_tag == bus.query_tagk)) begin
            bus.query_rdyk = 1'b1;
            bus.query_valk = bus.lsb_val;
        end
        if (bus.alu_valid && (bus.alu_tag == bus.query_tagk)) begin
            bus.query_rdyk = 1'b1;
            bus.query_valk = bus.alu_val;
        end
`endif
    end

    // Entry array, pointers and registered retire outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
            bus.commit_valid <= 1'b0;
            bus.commit_store <= 1'b0;
            bus.rollback     <= 1'b0;
            bus.rollback_pc  <= '0;
            bus.halt         <= 1'b0;
            bus.ROB_rd       <= '0;
            bus.ROB_rdTag    <= '0;
            bus.ROB_rdVal    <= '0;
        end else if (bus.rdy) begin
            bus.commit_valid <= 1'b0;
            bus.commit_store <= 1'b0;
            bus.rollback     <= 1'b0;

            if (retire) begin
                case (head_e.kind)
                    ROB_REG: begin
                        bus.commit_valid <= 1'b1;
                        bus.ROB_rd       <= head_e.rd;
                        bus.ROB_rdTag    <= head;
                        bus.ROB_rdVal    <= head_e.val;
                    end
                    ROB_STORE: begin
                        bus.commit_store <= 1'b1;
                        bus.ROB_rdTag    <= head;
                    end
                    ROB_BRANCH: begin
                        if (mispredict) begin
                            bus.rollback    <= 1'b1;
                            bus.rollback_pc <= redirect_pc(head_e);
                        end
                    end
                    ROB_EXIT: begin
                        bus.halt <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    entries[i].busy  <= 1'b0;
                    entries[i].ready <= 1'b0;
                end
            end else begin
                if (bus.alu_valid && entries[bus.alu_tag].busy) begin
                    entries[bus.alu_tag].ready      <= 1'b1;
                    entries[bus.alu_tag].val        <= bus.alu_val;
                    entries[bus.alu_tag].real_taken <= bus.alu_realTaken;
                    entries[bus.alu_tag].target     <= bus.alu_target;
                end
                if (bus.lsb_valid && entries[bus.lsb_tag].busy) begin
                    entries[bus.lsb_tag].ready <= 1'b1;
                    entries[bus.lsb_tag].val   <= bus.lsb_val;
                end
                if (retire) begin
                    entries[head].busy  <= 1'b0;
                    entries[head].ready <= 1'b0;
                    head                <= head + rob_range_t'(1);
                end
                // Issue is applied last so a full-buffer issue overwrites the retiring slot
                if (issue_take) begin
                    entries[tail] <= '{busy:       1'b1,
                                       ready:      bus.issue_ready,
                                       kind:       rob_type_t'(bus.issue_type),
                                       rd:         bus.issue_rd,
                                       pc:         bus.issue_pc,
                                       pred_taken: bus.issue_predTaken,
                                       real_taken: 1'b0,
                                       target:     '0,
                                       val:        bus.issue_val};
                    tail <= tail + rob_range_t'(1);
                end
                count <= count + rob_count_t'(issue_take) - rob_count_t'(retire);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a program-order queue model predicts
// every retire event and its cycle; a monitor compares DUT output pulses.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          tag;
        int          kind;
        int          rd;
        logic [31:0] pc;
        bit          pred;
        bit          rdy;
        logic [31:0] val;
        bit          rt;
        logic [31:0] target;
    } m_entry_t;

    // ev: 0 register commit, 1 store commit, 2 rollback, 3 halt
    typedef struct {
        int          ev;
        int          edge_no;
        int          rd;
        int          tag;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    m_entry_t mq[$];
    exp_t     sb[$];
    int       m_tail;
    bit       m_rb;
    bit       m_halt;
    int       edges;
    int       n_pass;
    int       n_total;
    bit       mon_en;
    bit       prev_halt;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edges);
    endfunction

    function int find(input int tag);
        foreach (mq[i]) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    function void model_query(input int tag, output bit r, output logic [31:0] v);
        int idx;
        r = 1'b0;
        v = '0;
        idx = find(tag);
        if (idx >= 0 && mq[idx].rdy) begin
            r = 1'b1;
            v = mq[idx].val;
        end
`ifdef ROB_QUERY_BYPASS_EN
        if (bus.lsb_valid && int'(bus.lsb_tag) == tag) begin r = 1'b1; v = bus.lsb_val; end
        if (bus.alu_valid && int'(bus.alu_tag) == tag) begin r = 1'b1; v = bus.alu_val; end
`endif
    endfunction

    function void push_exp(input int ev, input int rd, input int tag,
                           input logic [31:0] val, input logic [31:0] pc);
        exp_t x;
        x.ev = ev; x.edge_no = edges; x.rd = rd; x.tag = tag; x.val = val; x.pc = pc;
        sb.push_back(x);
    endfunction

    // Behaviour of one clock edge, from the current input values
    function void model_edge();
        m_entry_t e;
        bit       retiring;
        bit       was_full;
        int       idx;
        edges++;
        if (rst) begin
            mq.delete(); m_tail = 0; m_rb = 1'b0; m_halt = 1'b0;
            return;
        end
        if (!bus.rdy) return;
        if (m_rb) begin
            mq.delete(); m_tail = 0; m_rb = 1'b0;
            return;
        end
        was_full = (mq.size() == ROB_SIZE);
        retiring = (mq.size() > 0) && mq[0].rdy;
        if (retiring) begin
            e = mq[0];
            case (e.kind)
                0: push_exp(0, e.rd, e.tag, e.val, 0);
                1: push_exp(1, 0, e.tag, 0, 0);
                2: if (e.pred != e.rt) begin
                       push_exp(2, 0, 0, 0, e.rt ? e.target : e.pc + 32'd4);
                       mq.delete(); m_tail = 0; m_rb = 1'b1;
                       return;
                   end
                default: if (!m_halt) begin push_exp(3, 0, 0, 0, 0); m_halt = 1'b1; end
            endcase
            void'(mq.pop_front());
        end
        if (bus.alu_valid) begin
            idx = find(int'(bus.alu_tag));
            if (idx >= 0) begin
                mq[idx].rdy = 1'b1; mq[idx].val = bus.alu_val;
                mq[idx].rt = bus.alu_realTaken; mq[idx].target = bus.alu_target;
            end
        end
        if (bus.lsb_valid) begin
            idx = find(int'(bus.lsb_tag));
            if (idx >= 0) begin mq[idx].rdy = 1'b1; mq[idx].val = bus.lsb_val; end
        end
        if (bus.issue_valid && (!was_full || retiring)) begin
            e.tag = m_tail; e.kind = int'(bus.issue_type); e.rd = int'(bus.issue_rd);
            e.pc = bus.issue_pc; e.pred = bus.issue_predTaken; e.rdy = bus.issue_ready;
            e.val = bus.issue_val; e.rt = 1'b0; e.target = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % ROB_SIZE;
        end
    endfunction

    task automatic idle();
        bus.rdy = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_type = '0; bus.issue_rd = '0; bus.issue_pc = '0;
        bus.issue_predTaken = 1'b0; bus.issue_ready = 1'b0; bus.issue_val = '0;
        bus.alu_valid = 1'b0; bus.alu_tag = '0; bus.alu_val = '0;
        bus.alu_realTaken = 1'b0; bus.alu_target = '0;
        bus.lsb_valid = 1'b0; bus.lsb_tag = '0; bus.lsb_val = '0;
        bus.query_tagj = rob_range_t'($urandom_range(0, ROB_SIZE - 1));
        bus.query_tagk = rob_range_t'($urandom_range(0, ROB_SIZE - 1));
    endtask

    task automatic set_issue(input int ty, input int rd, input logic [31:0] pc,
                             input bit pred, input bit rdyv, input logic [31:0] v);
        bus.issue_valid = 1'b1; bus.issue_type = 2'(ty); bus.issue_rd = 5'(rd);
        bus.issue_pc = pc; bus.issue_predTaken = pred; bus.issue_ready = rdyv; bus.issue_val = v;
    endtask

    task automatic set_alu(input int tag, input logic [31:0] v, input bit rt, input logic [31:0] tgt);
        bus.alu_valid = 1'b1; bus.alu_tag = rob_range_t'(tag); bus.alu_val = v;
        bus.alu_realTaken = rt; bus.alu_target = tgt;
    endtask

    task automatic set_lsb(input int tag, input logic [31:0] v);
        bus.lsb_valid = 1'b1; bus.lsb_tag = rob_range_t'(tag); bus.lsb_val = v;
    endtask

    // Pre-edge checks of combinational outputs, then one clock edge
    task automatic step();
        bit          er;
        logic [31:0] ev;
        #1;
        check("issue_tag", bus.issue_tag, m_tail);
        check("rob_full", bus.rob_full, mq.size() == ROB_SIZE);
        check("halt", bus.halt, m_halt);
        model_query(int'(bus.query_tagj), er, ev);
        check("query_rdyj", bus.query_rdyj, er);
        if (er) check("query_valj", bus.query_valj, ev);
        model_query(int'(bus.query_tagk), er, ev);
        check("query_rdyk", bus.query_rdyk, er);
        if (er) check("query_valk", bus.query_valk, ev);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin idle(); step(); end
    endtask

    function int pick_free(input int avoid);
        int t;
        t = $urandom_range(0, ROB_SIZE - 1);
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (find(t) < 0 && t != avoid) return t;
            t = (t + 1) % ROB_SIZE;
        end
        return -1;
    endfunction

    // Monitor: every retire pulse is matched against the scoreboard head
    initial begin
        exp_t x;
        bit   rise;
        prev_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].edge_no < edges) begin
                    x = sb.pop_front();
                    check("missing_event_edge", 32'(x.edge_no), 32'(edges));
                end
                rise = bus.halt && !prev_halt;
                if (bus.commit_valid || bus.commit_store || bus.rollback || rise) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", {bus.commit_valid, bus.commit_store, bus.rollback, rise}, 0);
                    end else begin
                        x = sb.pop_front();
                        check("event_kind", {bus.commit_valid, bus.commit_store, bus.rollback, rise},
                              32'h8 >> x.ev);
                        check("event_edge", 32'(edges), 32'(x.edge_no));
                        case (x.ev)
                            0: begin
                                check("ROB_rd", bus.ROB_rd, x.rd);
                                check("ROB_rdTag", bus.ROB_rdTag, x.tag);
                                check("ROB_rdVal", bus.ROB_rdVal, x.val);
                            end
                            1: check("store_tag", bus.ROB_rdTag, x.tag);
                            2: check("rollback_pc", bus.rollback_pc, x.pc);
                            default: ;
                        endcase
                    end
                end
            end
            prev_halt = bus.halt;
        end
    end

    initial begin
        int cand[$];
        int r, ty, ti, t;
        n_pass = 0; n_total = 0; edges = 0; mon_en = 1'b0;
        m_tail = 0; m_rb = 1'b0; m_halt = 1'b0;
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_commit_valid", bus.commit_valid, 0);
        check("rst_commit_store", bus.commit_store, 0);
        check("rst_rollback", bus.rollback, 0);
        check("rst_rollback_pc", bus.rollback_pc, 0);
        check("rst_halt", bus.halt, 0);
        check("rst_ROB_rd", bus.ROB_rd, 0);
        check("rst_ROB_rdTag", bus.ROB_rdTag, 0);
        check("rst_ROB_rdVal", bus.ROB_rdVal, 0);
        check("rst_rob_full", bus.rob_full, 0);
        check("rst_issue_tag", bus.issue_tag, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single register result
        idle(); set_issue(0, 5, 32'h40, 0, 0, 0); step();
        idle(); set_alu(0, 32'h1234, 0, 0); step();
        idle_steps(3);

        // Fill to capacity, refused 17th issue, issue into the retiring slot
        for (int i = 0; i < ROB_SIZE; i++) begin
            idle(); set_issue(0, i + 1, 32'h1000 + 32'(4 * i), 0, 0, 0); step();
        end
        idle(); set_issue(0, 31, 32'h2000, 0, 0, 0); step();
        idle(); set_alu(mq[0].tag, 32'hA0, 0, 0); step();
        idle(); set_issue(0, 30, 32'h2004, 0, 0, 32'h0); step();
        // Out-of-order results, in-order commits
        idle(); set_alu(mq[1].tag, 32'hB1, 0, 0); step();
        idle(); set_alu(mq[0].tag, 32'hB0, 0, 0); step();
        while (mq.size() > 0 && edges < 200) begin
            idle();
            cand.delete();
            foreach (mq[i]) if (!mq[i].rdy) cand.push_back(mq[i].tag);
            if (cand.size() > 0) set_alu(cand[0], $urandom, 0, 0);
            if (cand.size() > 1) set_lsb(cand[1], $urandom);
            step();
        end
        idle_steps(3);

        // Mispredicted branch with two younger entries; issues during flush ignored
        idle(); set_issue(2, 0, 32'h100, 0, 0, 0); step();
        idle(); set_issue(0, 7, 32'h104, 0, 0, 0); step();
        idle(); set_issue(1, 0, 32'h108, 0, 0, 0); step();
        idle(); set_alu(mq[1].tag, 32'h77, 0, 0); set_lsb(mq[2].tag, 32'h0); step();
        idle(); set_alu(mq[0].tag, 32'h0, 1, 32'h200); step();
        idle(); set_issue(0, 9, 32'h300, 0, 1, 32'h5); step();
        idle(); set_issue(0, 9, 32'h300, 0, 1, 32'h5); step();
        idle(); set_issue(0, 9, 32'h300, 0, 1, 32'h5); step();
        // Store commit
        idle(); set_issue(1, 0, 32'h400, 0, 0, 0); step();
        idle(); set_lsb(mq[mq.size() - 1].tag, 32'hDEAD); step();
        idle_steps(3);

        // Same-cycle CDB visible to query only with bypass
        idle(); set_issue(0, 3, 32'h500, 0, 0, 0); step();
        idle(); set_issue(0, 4, 32'h504, 0, 0, 0); step();
        idle(); t = mq[mq.size() - 1].tag;
        set_alu(t, 32'h7, 0, 0); bus.query_tagj = rob_range_t'(t); bus.query_tagk = rob_range_t'(t); step();
        idle(); bus.query_tagj = rob_range_t'(t); step();
        idle(); set_alu(mq[0].tag, 32'h8, 0, 0); step();
        idle_steps(4);

        // Global enable low: nothing moves
        for (int i = 0; i < 3; i++) begin
            idle(); bus.rdy = 1'b0; set_issue(0, 1, 32'h600, 0, 1, 32'h1); step();
        end

        // EXIT sets sticky halt; mid-operation reset clears it regardless of rdy
        idle(); set_issue(3, 0, 32'h700, 0, 1, 0); step();
        idle(); set_issue(0, 2, 32'h704, 0, 0, 0); step();
        idle_steps(3);
        idle(); bus.rdy = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        idle_steps(2);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 99);
                ty = (r < 50) ? 0 : (r < 65) ? 1 : (r < 98) ? 2 : 3;
                set_issue(ty, $urandom_range(0, 31), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
                          (ty == 0) && ($urandom_range(0, 2) == 0), $urandom);
            end
            cand.delete();
            foreach (mq[i]) if (!mq[i].rdy) cand.push_back(mq[i].tag);
            t = -1;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                ti = $urandom_range(0, cand.size() - 1);
                t = cand[ti];
                cand.delete(ti);
                set_alu(t, $urandom, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
            end else if ($urandom_range(0, 9) == 0) begin
                t = pick_free(-1);
                if (t >= 0) set_alu(t, $urandom, 1, 32'h0);
            end
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                set_lsb(cand[$urandom_range(0, cand.size() - 1)], $urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                ti = pick_free(t);
                if (ti >= 0) set_lsb(ti, $urandom);
            end
            step();
        end

        // Drain
        for (int i = 0; i < 60 && mq.size() > 0; i++) begin
            idle();
            cand.delete();
            foreach (mq[j]) if (!mq[j].rdy) cand.push_back(mq[j].tag);
            if (cand.size() > 0) set_alu(cand[0], $urandom, 0, 0);
            step();
        end
        idle_steps(3);
        check("scoreboard_drained", sb.size(), 0);
        check("model_drained", mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
